pht_update_queue: RTL and testbench
===================================

Name: pht_update_queue

Overview:
- Parametrised successor to the fixed 32-entry, single-port PHT write queue: buffers branch-predictor counter updates from commit and drains them into a banked PHT when the target bank's port is not used by fetch.
- Generalised in counter width, queue depth, enqueue lanes and bank count.
- Computes the saturating counter update itself, so committers send direction plus previous value.
- Sits between the commit-side branch-result path and the PHT array.

Parameters:
- ENTRY_NUM, 2048, PHT entries (power of two); IDX_W = $clog2(ENTRY_NUM)
- CTR_WIDTH, 2, saturating counter width; CTR_MAX = (1<<CTR_WIDTH)-1
- QUEUE_DEPTH, 32, queue entries (power of two, >= 2*ENQ_WIDTH)
- ENQ_WIDTH, 2, update lanes per cycle; lane 0 is oldest
- BANK_NUM, 2, PHT banks (power of two); bank = index[$clog2(BANK_NUM)-1:0]

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enqValid  in  ENQ_WIDTH  per-lane update request
- enqIndex  in  ENQ_WIDTH x IDX_W  PHT index per lane
- enqTaken  in  ENQ_WIDTH  executed branch direction
- enqPrev  in  ENQ_WIDTH x CTR_WIDTH  counter value read at prediction time
- enqReady  out  1  all lanes may enqueue this cycle
- bankBusy  in  BANK_NUM  bank read port used by fetch this cycle
- wrValid  out  1  PHT write strobe
- wrIndex  out  IDX_W  PHT write index
- wrValue  out  CTR_WIDTH  PHT write data
- count  out  $clog2(QUEUE_DEPTH)+1  occupied entries
- overflow  out  1  sticky: an update was dropped

Behaviour:
- Reset (async assert, sync release): head = tail = count = 0; overflow = 0; enqReady = 1; wrValid = 0; wrIndex = 0; wrValue = 0.
- Storage: circular buffer of {index, value}. Head and tail wrap modulo QUEUE_DEPTH.
- enqReady = (QUEUE_DEPTH - count) >= ENQ_WIDTH, computed from registered count only. A same-cycle dequeue does not raise it.
- Enqueue lane value:
  - taken: min(prev+1, CTR_MAX)
  - not taken: max(prev-1, 0)
  - All arithmetic is in CTR_WIDTH+1 bits, then truncated.
- Enqueue ordering: valid lanes are written in lane order, compacted, starting at tail. Invalid lanes leave no gap. Tail advances by popcount(enqValid).
- enqValid with enqReady = 0: the whole cycle's lanes are dropped, overflow is set to 1, and the queue is unchanged.
- Dequeue:
  - Condition: count != 0 and bankBusy[bank(head.index)] == 0. When it holds, in the same cycle wrValid = 1, wrIndex = head.index, wrValue = head.value, and head advances by 1.
  - Outputs are combinational from registered head state.
  - Strict in-order: a blocked head stalls the whole queue. No bypass of younger entries.
- Latency: an entry enqueued in cycle t is written no earlier than cycle t+1. An empty queue never forwards input directly to the write port.
- Simultaneous enqueue and dequeue: count_next = count + popcount(accepted lanes) - deq. It is legal at count = QUEUE_DEPTH - ENQ_WIDTH.
- Same index in several lanes or entries: entries are written in order, so the youngest value lands last. No coalescing.
- Full (count = QUEUE_DEPTH): enqReady = 0 and dequeue proceeds normally.
- Wrap-around: pointer arithmetic modulo QUEUE_DEPTH. Data must be correct across the boundary when a multi-lane enqueue straddles it.
- Reset mid-operation: all queued updates are discarded immediately and outputs return to reset values within the same cycle.
- States: EMPTY (count = 0), ACTIVE, FULL (count = QUEUE_DEPTH). These are derived from count; there is no separate state register.
- Assertions:
  - count <= QUEUE_DEPTH.
  - wrValid implies !bankBusy[bank(wrIndex)].

Decomposition:
- Into FetchUnitTypes:
  - PHT_IndexPath and PHT_EntryPath, generalised to CTR_WIDTH.
  - PhtQueueEntry, with the index stored as PHT_IndexPath.
  - PHT_QUEUE_SIZE replaced by CONF_PHT_QUEUE_SIZE from MicroArchConf.
  - Function ToPHT_Bank(PHT_IndexPath).
  - Function SatCounterUpdate(PHT_EntryPath prev, logic taken).
- Sub-module: pht_queue_enq_compactor, combinational. Maps enqValid to per-lane write offsets and popcount.

Test Plan:
- Reset, then one lane {index 0x010, taken, prev 2'b01}, bankBusy = 0 → the next cycle shows wrValid = 1, wrIndex = 0x010, wrValue = 2'b10; count returns to 0.
- Saturation: {taken, prev 3} → wrValue 3. {not taken, prev 0} → wrValue 0. With CTR_WIDTH = 3: {taken, prev 7} → 7.
- Lanes enqValid = 2'b10 with index 0x005 → stored at tail slot 0 and tail +1. Then 2'b11 with 0x006/0x007 → drained in order 0x005, 0x006, 0x007.
- Bank stall: head index 0x004 (bank 0) with bankBusy = 2'b01 for 3 cycles → wrValid = 0 for 3 cycles. A younger bank-1 entry is not written. On release, 0x004 is written first.
- Fill to 31 with BANK_NUM busy → enqReady = 0. A 2-lane enqueue is dropped, overflow = 1, count stays 31. After 1 drain, enqReady = 1.
- Wrap: tail = 31, 2-lane enqueue → entries in slots 31 and 0, drained in order. Assert rst mid-drain → wrValid = 0 and count = 0 immediately.

Source files
------------

// File: rtl/pht_update_queue_pkg.sv
// Shared PHT update-queue types, default micro-architecture configuration and
// the counter/bank helper functions used by the queue and its bench.
package pht_update_queue_pkg;

   localparam int CONF_PHT_ENTRY_NUM  = 2048;
   localparam int CONF_PHT_CTR_WIDTH  = 2;
   localparam int CONF_PHT_QUEUE_SIZE = 32;
   localparam int CONF_PHT_ENQ_WIDTH  = 2;
   localparam int CONF_PHT_BANK_NUM   = 2;

   localparam int PHT_IDX_W = $clog2(CONF_PHT_ENTRY_NUM);
   // Widest counter the shared saturating-update helper supports.
   localparam int SAT_MAX_W = 8;

   typedef logic [PHT_IDX_W-1:0]          pht_index_t;
   typedef logic [CONF_PHT_CTR_WIDTH-1:0] pht_entry_t;

   typedef struct packed {
      pht_index_t index;
      pht_entry_t value;
   } pht_queue_entry_t;

   function automatic logic [31:0] to_pht_bank(input logic [31:0] index,
                                               input int unsigned bank_num);
      return index & (bank_num - 1);
   endfunction

   // Computed one bit wider than the counter so prev+1 cannot wrap before the clamp.
   function automatic logic [SAT_MAX_W-1:0] sat_counter_update(input logic [SAT_MAX_W-1:0] prev,
                                                               input logic taken,
                                                               input int unsigned ctr_width);
      logic [SAT_MAX_W:0] wide;
      logic [SAT_MAX_W:0] ctr_max;
      ctr_max = (SAT_MAX_W+1)'((1 << ctr_width) - 1);
      wide    = {1'b0, prev};
      if (taken) begin
         wide = wide + 1;
         if (wide > ctr_max) wide = ctr_max;
      end else if (wide != '0) begin
         wide = wide - 1;
      end
      return wide[SAT_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/pht_update_queue_if.sv
// Commit-side enqueue lanes, fetch bank-busy mask and PHT write port of the
// PHT update queue, bundled for the queue (slave) and its driver (master).
interface pht_update_queue_if
   import pht_update_queue_pkg::*;
#(
   parameter int ENTRY_NUM   = CONF_PHT_ENTRY_NUM,
   parameter int CTR_WIDTH   = CONF_PHT_CTR_WIDTH,
   parameter int QUEUE_DEPTH = CONF_PHT_QUEUE_SIZE,
   parameter int ENQ_WIDTH   = CONF_PHT_ENQ_WIDTH,
   parameter int BANK_NUM    = CONF_PHT_BANK_NUM
);
   localparam int IDX_W = $clog2(ENTRY_NUM);
   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   logic [ENQ_WIDTH-1:0]                enqValid;
   logic [ENQ_WIDTH-1:0][IDX_W-1:0]     enqIndex;
   logic [ENQ_WIDTH-1:0]                enqTaken;
   logic [ENQ_WIDTH-1:0][CTR_WIDTH-1:0] enqPrev;
   logic                                enqReady;
   logic [BANK_NUM-1:0]                 bankBusy;
   logic                                wrValid;
   logic [IDX_W-1:0]                    wrIndex;
   logic [CTR_WIDTH-1:0]                wrValue;
   logic [CNT_W-1:0]                    count;
   logic                                overflow;

   modport master (
      output enqValid, enqIndex, enqTaken, enqPrev, bankBusy,
      input  enqReady, wrValid, wrIndex, wrValue, count, overflow
   );

   modport slave (
      input  enqValid, enqIndex, enqTaken, enqPrev, bankBusy,
      output enqReady, wrValid, wrIndex, wrValue, count, overflow
   );

endinterface

// File: rtl/pht_queue_enq_compactor.sv
// Maps the per-lane enqueue valid mask to compacted slot offsets from the tail
// (lane 0 oldest) and the number of valid lanes.
module pht_queue_enq_compactor #(
   parameter int ENQ_WIDTH = 2,
   parameter int OFF_W     = $clog2(ENQ_WIDTH) + 1
) (
   input  logic [ENQ_WIDTH-1:0]            valid,
   output logic [ENQ_WIDTH-1:0][OFF_W-1:0] offset,
   output logic [OFF_W-1:0]                total
);

   logic [OFF_W-1:0] acc;

   // NOTE: blocking assignments here are intentional; acc is a running sum
   // that each loop iteration must see updated within the same evaluation.
   always_comb begin
      acc    = '0;
      offset = '0;
      for (int i = 0; i < ENQ_WIDTH; i++) begin
         offset[i] = acc;
         acc       = acc + OFF_W'(valid[i]);
      end
      total = acc;
   end

endmodule

// File: rtl/pht_update_queue.sv
// In-order circular queue of PHT counter updates from commit, drained one per
// cycle into the banked PHT whenever the head entry's bank is not used by fetch.
module pht_update_queue
   import pht_update_queue_pkg::*;
#(
   parameter int ENTRY_NUM   = CONF_PHT_ENTRY_NUM,
   parameter int CTR_WIDTH   = CONF_PHT_CTR_WIDTH,
   parameter int QUEUE_DEPTH = CONF_PHT_QUEUE_SIZE,
   parameter int ENQ_WIDTH   = CONF_PHT_ENQ_WIDTH,
   parameter int BANK_NUM    = CONF_PHT_BANK_NUM
) (
   input logic               clk,
   input logic               rst,
   pht_update_queue_if.slave bus
);

   localparam int IDX_W  = $clog2(ENTRY_NUM);
   localparam int PTR_W  = $clog2(QUEUE_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int OFF_W  = $clog2(ENQ_WIDTH) + 1;
   localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

   typedef struct packed {
      logic [IDX_W-1:0]     index;
      logic [CTR_WIDTH-1:0] value;
   } entry_t;

   entry_t mem [QUEUE_DEPTH];

   logic [PTR_W-1:0]                head;
   logic [PTR_W-1:0]                tail;
   logic [CNT_W-1:0]                cnt;
   logic                            overflow_q;
   logic [ENQ_WIDTH-1:0][OFF_W-1:0] offset;
   logic [OFF_W-1:0]                pop;
   entry_t                          lane_entry [ENQ_WIDTH];
   entry_t                          head_entry;
   logic [BANK_W-1:0]               head_bank;
   logic [BANK_W-1:0]               wr_bank;
   logic                            ready;
   logic                            any_valid;
   logic                            accept;
   logic                            deq;

   pht_queue_enq_compactor #(
      .ENQ_WIDTH (ENQ_WIDTH),
      .OFF_W     (OFF_W)
   ) u_compactor (
      .valid  (bus.enqValid),
      .offset (offset),
      .total  (pop)
   );

   // Readiness looks only at registered occupancy, so a same-cycle drain never frees room.
   assign ready     = cnt <= CNT_W'(QUEUE_DEPTH - ENQ_WIDTH);
   assign any_valid = |bus.enqValid;
   assign accept    = any_valid && ready;

   always_comb begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
         lane_entry[i].index = bus.enqIndex[i];
         lane_entry[i].value = CTR_WIDTH'(sat_counter_update(SAT_MAX_W'(bus.enqPrev[i]),
                                                             bus.enqTaken[i], CTR_WIDTH));
      end
   end

   assign head_entry = mem[head];
   assign head_bank  = BANK_W'(to_pht_bank(32'(head_entry.index), BANK_NUM));
   assign deq        = (cnt != '0) && !bus.bankBusy[head_bank];

   assign bus.enqReady = ready;
   assign bus.wrValid  = deq;
   assign bus.wrIndex  = deq ? head_entry.index : '0;
   assign bus.wrValue  = deq ? head_entry.value : '0;
   assign bus.count    = cnt;
   assign bus.overflow = overflow_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head       <= '0;
         tail       <= '0;
         cnt        <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) tail <= tail + PTR_W'(pop);
         if (deq) head <= head + PTR_W'(1);
         cnt <= cnt + (accept ? CNT_W'(pop) : CNT_W'(0)) - CNT_W'(deq);
         if (any_valid && !ready) overflow_q <= 1'b1;
      end
   end

   // NOTE: the storage array is deliberately not reset; head/tail/cnt define
   // which slots are live, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (bus.enqValid[i]) mem[tail + PTR_W'(offset[i])] <= lane_entry[i];
         end
      end
   end

   assign wr_bank = BANK_W'(to_pht_bank(32'(bus.wrIndex), BANK_NUM));

   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      cnt <= CNT_W'(QUEUE_DEPTH));

   a_write_bank_free: assert property (@(posedge clk) disable iff (rst)
      bus.wrValid |-> !bus.bankBusy[wr_bank]);

endmodule

// File: tb/tb_pht_update_queue.sv
// Scoreboard bench for pht_update_queue: accepted updates are queued with their
// expected counter value and compared against the PHT write port in order.
module tb_pht_update_queue;
   import pht_update_queue_pkg::*;

   localparam int DEPTH = 32;
   localparam int ENQ   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pht_update_queue_if bus ();
   pht_update_queue_if #(.CTR_WIDTH(3)) bus3 ();

   pht_update_queue dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pht_update_queue #(.CTR_WIDTH(3)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   int errors = 0;
   int checks = 0;

   pht_queue_entry_t sb[$];
   pht_queue_entry_t pend[$];
   logic model_ov = 1'b0;
   logic pend_ov  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] model_ctr(input logic [1:0] prev, input logic taken);
      if (taken) return (prev == 2'b11) ? 2'b11 : prev + 2'b01;
      return (prev == 2'b00) ? 2'b00 : prev - 2'b01;
   endfunction

   // One cycle of stimulus; accepted lanes become pending until this cycle's edge commits them.
   task automatic drive(input logic [1:0] v, input logic [10:0] i0, input logic [10:0] i1,
                        input logic [1:0] tk, input logic [1:0] p0, input logic [1:0] p1,
                        input logic [1:0] busy);
      @(posedge clk);
      #1;
      bus.enqValid    = v;
      bus.enqIndex[0] = i0;
      bus.enqIndex[1] = i1;
      bus.enqTaken    = tk;
      bus.enqPrev[0]  = p0;
      bus.enqPrev[1]  = p1;
      bus.bankBusy    = busy;
      if (v != 2'b00) begin
         if ((DEPTH - sb.size()) >= ENQ) begin
            if (v[0]) pend.push_back('{index: i0, value: model_ctr(p0, tk[0])});
            if (v[1]) pend.push_back('{index: i1, value: model_ctr(p1, tk[1])});
         end else begin
            pend_ov = 1'b1;
         end
      end
   endtask

   task automatic idle(input logic [1:0] busy);
      drive(2'b00, 11'h0, 11'h0, 2'b00, 2'b00, 2'b00, busy);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || pend.size() != 0) && n < 200) begin
         idle(2'b00);
         n++;
      end
      idle(2'b00);
      check("drain_budget", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         pend.delete();
         model_ov = 1'b0;
         pend_ov  = 1'b0;
      end else begin
         logic exp_v;
         pht_queue_entry_t e;
         check("count", bus.count, sb.size());
         check("enq_ready", bus.enqReady, (DEPTH - sb.size()) >= ENQ);
         check("overflow", bus.overflow, model_ov);
         exp_v = (sb.size() != 0) && !bus.bankBusy[sb[0].index[0]];
         check("wr_valid", bus.wrValid, exp_v);
         if (exp_v) begin
            e = sb.pop_front();
            if (bus.wrValid) begin
               check("wr_index", bus.wrIndex, e.index);
               check("wr_value", bus.wrValue, e.value);
            end
         end
         while (pend.size() != 0) sb.push_back(pend.pop_front());
         if (pend_ov) model_ov = 1'b1;
         pend_ov = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.enqValid  = '0;
      bus.enqIndex  = '0;
      bus.enqTaken  = '0;
      bus.enqPrev   = '0;
      bus.bankBusy  = '0;
      bus3.enqValid = '0;
      bus3.enqIndex = '0;
      bus3.enqTaken = '0;
      bus3.enqPrev  = '0;
      bus3.bankBusy = '0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_valid", bus.wrValid, 0);
      check("rst_wr_index", bus.wrIndex, 0);
      check("rst_wr_value", bus.wrValue, 0);
      check("rst_count", bus.count, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_enq_ready", bus.enqReady, 1);
      @(negedge clk);
      #2 rst = 1'b0;

      // 3-bit counters: taken at 7 saturates, not-taken at 0 stays 0
      @(posedge clk);
      #1;
      bus3.enqValid    = 2'b11;
      bus3.enqIndex[0] = 11'h007;
      bus3.enqIndex[1] = 11'h008;
      bus3.enqTaken    = 2'b01;
      bus3.enqPrev[0]  = 3'd7;
      bus3.enqPrev[1]  = 3'd0;
      @(posedge clk);
      #1;
      bus3.enqValid = 2'b00;
      @(negedge clk);
      check("c3_valid0", bus3.wrValid, 1);
      check("c3_index0", bus3.wrIndex, 11'h007);
      check("c3_value0", bus3.wrValue, 3'd7);
      @(negedge clk);
      check("c3_valid1", bus3.wrValid, 1);
      check("c3_index1", bus3.wrIndex, 11'h008);
      check("c3_value1", bus3.wrValue, 3'd0);

      // Single lane, one-cycle latency
      drive(2'b01, 11'h010, 11'h000, 2'b01, 2'b01, 2'b00, 2'b00);
      idle(2'b00);
      idle(2'b00);

      // Saturation and ordinary increments/decrements
      drive(2'b11, 11'h020, 11'h021, 2'b01, 2'b11, 2'b00, 2'b00);
      drive(2'b11, 11'h022, 11'h023, 2'b10, 2'b10, 2'b01, 2'b00);
      drain();

      // Compaction: lone lane 1, then both lanes
      drive(2'b10, 11'h000, 11'h005, 2'b10, 2'b00, 2'b01, 2'b00);
      drive(2'b11, 11'h006, 11'h007, 2'b01, 2'b01, 2'b10, 2'b00);
      drain();

      // Head blocked on bank 0 stalls a younger bank-1 entry
      drive(2'b11, 11'h004, 11'h009, 2'b11, 2'b01, 2'b01, 2'b01);
      repeat (3) idle(2'b01);
      drain();

      // Fill to 31, dropped enqueue sets overflow, one drain restores ready
      for (int k = 0; k < 15; k++)
         drive(2'b11, 11'(11'h100 + 2 * k), 11'(11'h101 + 2 * k), 2'b10, 2'b10, 2'b01, 2'b11);
      drive(2'b01, 11'h200, 11'h000, 2'b01, 2'b00, 2'b00, 2'b11);
      drive(2'b11, 11'h300, 11'h301, 2'b11, 2'b00, 2'b00, 2'b11);
      idle(2'b10);
      idle(2'b11);
      drain();

      // Reset pulse to realign pointers for the wrap-around case
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      for (int k = 0; k < 31; k++)
         drive(2'b01, 11'(11'h040 + k), 11'h000, 2'b01, 2'b01, 2'b00, 2'b00);
      drive(2'b11, 11'h031, 11'h032, 2'b10, 2'b01, 2'b10, 2'b00);
      drive(2'b11, 11'h0a0, 11'h0a1, 2'b01, 2'b00, 2'b11, 2'b00);
      idle(2'b00);
      idle(2'b00);

      // Reset while one entry is still queued
      @(posedge clk);
      #1;
      check("pre_rst_wr_valid", bus.wrValid, sb.size() != 0);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_wr_valid", bus.wrValid, 0);
      check("mid_rst_count", bus.count, 0);
      check("mid_rst_wr_index", bus.wrIndex, 0);
      check("mid_rst_enq_ready", bus.enqReady, 1);
      @(negedge clk);
      #2 rst = 1'b0;
      idle(2'b00);
      idle(2'b00);
      @(negedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
